// File: rtl/gate_reduce_pipe.sv
// Registered, flow-controlled bitwise reduction (AND/NAND/OR/NOR/XOR/XNOR) across
// N_INPUTS operands, with an output register plus a skid slot for full throughput.
module gate_reduce_pipe #(
  parameter int N_INPUTS = 3,
  parameter int WIDTH    = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_INPUTS*WIDTH-1:0] in_data,
  input  logic [2:0]                in_op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_illegal,
  output logic                      err_sticky,
  output logic [CNT_W-1:0]          txn_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t             state_q, state_d;
  logic               in_ready_q;
  logic [WIDTH-1:0]   red_and, red_or, red_xor;
  logic [WIDTH-1:0]   res_d, out_data_q, skid_data_q;
  logic               ill_d, out_ill_q, skid_ill_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_xfer, out_xfer;
  logic               load_out, load_skid, skid_to_out;

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != EMPTY);
  assign out_data    = out_data_q;
  assign out_illegal = out_ill_q;
  assign err_sticky  = err_q;
  assign txn_count   = cnt_q;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    red_and = '1;
    red_or  = '0;
    red_xor = '0;
    for (int unsigned k = 0; k < N_INPUTS; k++) begin
      red_and = red_and & in_data[k*WIDTH +: WIDTH];
      red_or  = red_or  | in_data[k*WIDTH +: WIDTH];
      red_xor = red_xor ^ in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    res_d = '0;
    ill_d = 1'b0;
    case (in_op)
      3'd0:    res_d = red_and;
      3'd1:    res_d = ~red_and;
      3'd2:    res_d = red_or;
      3'd3:    res_d = ~red_or;
      3'd4:    res_d = red_xor;
      3'd5:    res_d = ~red_xor;
      default: ill_d = 1'b1;
    endcase
  end

  // No input can arrive in TWO because in_ready is registered low there.
  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state_q)
      EMPTY: if (in_xfer) begin
        load_out = 1'b1;
        state_d  = ONE;
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_out = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_d   = TWO;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: if (out_xfer) begin
        skid_to_out = 1'b1;
        state_d     = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_data_q  <= '0;
      out_ill_q   <= 1'b0;
      skid_data_q <= '0;
      skid_ill_q  <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      if (load_out) begin
        out_data_q <= res_d;
        out_ill_q  <= ill_d;
      end else if (skid_to_out) begin
        out_data_q <= skid_data_q;
        out_ill_q  <= skid_ill_q;
      end
      if (load_skid) begin
        skid_data_q <= res_d;
        skid_ill_q  <= ill_d;
      end
      if (in_xfer && ill_d)
        err_q <= 1'b1;
      if (in_xfer && cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
